// File: rtl/cv_seq_capture_if.sv
// Bundle between the sequence generator / consumer side and the capture block.
// Handshake: an entry moves from the capture FIFO to the consumer on a rising
// CLK edge exactly when RD_VLD and RD_RDY are both high. RD_VLD never waits on
// RD_RDY. The head entry (RD_SEQ/RD_NOM) stays stable until the edge that pops
// it. RD_RDY may be high while RD_VLD is low; nothing moves then.
interface cv_seq_capture_if #(
   parameter int DEPTH = 8,
   parameter int W     = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic          STEP;
   logic [W-1:0]  SEQ;
   logic [W-1:0]  NOM;
   logic          EN;
   logic          TRIG;
   logic [W-1:0]  MATCH_VAL;
   logic          CLR;
   logic          RD_RDY;
   logic          RD_VLD;
   logic [W-1:0]  RD_SEQ;
   logic [W-1:0]  RD_NOM;
   logic [CW-1:0] CNT;
   logic          FULL;
   logic          EMPTY;
   logic          OVF;
   logic          MATCH;
   logic [1:0]    STATE;

   // Generator / consumer side.
   modport master (
      output STEP, SEQ, NOM, EN, TRIG, MATCH_VAL, CLR, RD_RDY,
      input  RD_VLD, RD_SEQ, RD_NOM, CNT, FULL, EMPTY, OVF, MATCH, STATE
   );

   // Capture block side.
   modport slave (
      input  STEP, SEQ, NOM, EN, TRIG, MATCH_VAL, CLR, RD_RDY,
      output RD_VLD, RD_SEQ, RD_NOM, CNT, FULL, EMPTY, OVF, MATCH, STATE
   );
endinterface

// File: rtl/cv_seq_capture.sv
// Captures {SEQ,NOM} on rising edges of STEP into a first-word-fall-through
// FIFO, either freely (TRIG=0) or after SEQ first equals MATCH_VAL (TRIG=1).
// STATE is exported so the capture phase is always observable.
module cv_seq_capture #(
   parameter int DEPTH = 8,
   parameter int W     = 4
) (
   input  logic            CLK,
   input  logic            RST,
   cv_seq_capture_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   localparam logic [1:0]    S_IDLE   = 2'd0;
   localparam logic [1:0]    S_ARM    = 2'd1;
   localparam logic [1:0]    S_RUN    = 2'd2;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic           step_q;
   logic [1:0]     state;
   logic [1:0]     state_nxt;
   logic [CW-1:0]  cnt;
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic           ovf;
   logic           match_q;
   logic [2*W-1:0] mem [DEPTH];

   logic step_ev;
   logic hit;
   logic wr_req;
   logic full;
   logic empty;
   logic pop;
   logic do_wr;
   logic drop;

   // A step event is the first cycle STEP is seen high; hit marks an event
   // whose SEQ equals the compare value.
   assign step_ev = bus.STEP & ~step_q;
   assign hit     = step_ev & (bus.SEQ == bus.MATCH_VAL);

   // The trigger sample itself is recorded, so ARM writes on the matching event.
   assign wr_req = step_ev & ((state == S_RUN) | ((state == S_ARM) & hit));
   assign full   = (cnt == CNT_FULL);
   assign empty  = (cnt == '0);
   assign pop    = ~empty & bus.RD_RDY;
   // A pop frees the slot at the same edge, so a full FIFO still accepts then.
   assign do_wr  = wr_req & (~full | pop);
   assign drop   = wr_req & full & ~pop;

   // Capture phase sequencing; dropping EN always returns to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (bus.EN) state_nxt = bus.TRIG ? S_ARM : S_RUN;
         S_ARM: begin
            if (!bus.EN)  state_nxt = S_IDLE;
            else if (hit) state_nxt = S_RUN;
         end
         S_RUN:  if (!bus.EN) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Edge detector history; keeps sampling through CLR.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) step_q <= 1'b0;
      else      step_q <= bus.STEP;
   end

   // Phase, sticky overflow and the one-cycle match pulse.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= S_IDLE;
         ovf     <= 1'b0;
         match_q <= 1'b0;
      end else if (bus.CLR) begin
         state   <= S_IDLE;
         ovf     <= 1'b0;
         match_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         match_q <= hit & (state != S_IDLE);
         if (drop) ovf <= 1'b1;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (bus.CLR) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PW'(1);
         if (pop)   rd_ptr <= rd_ptr + PW'(1);
         case ({do_wr, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Entry storage; contents need no reset since EMPTY masks the read port.
   always_ff @(posedge CLK) begin
      if (do_wr && !bus.CLR) mem[wr_ptr] <= {bus.SEQ, bus.NOM};
   end

   assign bus.RD_VLD = ~empty;
   assign bus.RD_SEQ = empty ? '0 : mem[rd_ptr][2*W-1:W];
   assign bus.RD_NOM = empty ? '0 : mem[rd_ptr][W-1:0];
   assign bus.CNT    = cnt;
   assign bus.FULL   = full;
   assign bus.EMPTY  = empty;
   assign bus.OVF    = ovf;
   assign bus.MATCH  = match_q;
   assign bus.STATE  = state;
endmodule

// File: doc/cv_seq_capture.md
CV_SEQ_CAPTURE -- requirements
Module: cv_seq_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning capture FIFO depth in entries (power of two, 2..16).
REQ-002 SHALL have parameter W, default 4, meaning width of SEQ and NOM words.
REQ-003 SHALL have port CLK  input  1  rising-edge clock for all state.
REQ-004 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port STEP  input  1  step strobe from the sequence generator, sampled on CLK.
REQ-006 SHALL have port SEQ  input  W  current sequence value from the generator.
REQ-007 SHALL have port NOM  input  W  current sequence index from the generator.
REQ-008 SHALL have port EN  input  1  capture enable, level.
REQ-009 SHALL have port TRIG  input  1  trigger mode select: 1 = wait for MATCH_VAL before recording.
REQ-010 SHALL have port MATCH_VAL  input  W  trigger and match compare value.
REQ-011 SHALL have port CLR  input  1  synchronous clear.
REQ-012 SHALL have port RD_RDY  input  1  consumer ready.
REQ-013 SHALL have port RD_VLD  output  1  head entry valid.
REQ-014 SHALL have port RD_SEQ  output  W  head entry SEQ field.
REQ-015 SHALL have port RD_NOM  output  W  head entry NOM field.
REQ-016 SHALL have port CNT  output  clog2(DEPTH+1)  number of stored entries.
REQ-017 SHALL have ports FULL, EMPTY, OVF, MATCH  output  1 each  full, empty, sticky overflow, match pulse.
REQ-018 SHALL have port STATE  output  2  capture state: IDLE=0, ARM=1, RUN=2.

Function
REQ-019 SHALL register STEP into step_q each cycle; step event = STEP & ~step_q.
REQ-020 SHALL sample SEQ/NOM in the same cycle the step event is detected.
REQ-021 SHALL implement FSM: IDLE->ARM when EN & TRIG; IDLE->RUN when EN & ~TRIG; ARM->RUN on step event with SEQ==MATCH_VAL; ARM/RUN->IDLE when EN=0.
REQ-022 SHALL write {SEQ,NOM} on a step event only in RUN, or in ARM when the event is the trigger match; the trigger sample is the first entry.
REQ-023 SHALL discard step events in IDLE and non-matching events in ARM.
REQ-024 SHALL be a first-word-fall-through FIFO: RD_VLD = ~EMPTY; RD_SEQ/RD_NOM show the head and are forced to 0 when EMPTY.
REQ-025 SHALL pop the head on the rising edge where RD_VLD & RD_RDY.
REQ-026 SHALL make a written entry visible (RD_VLD=1 when previously empty) one cycle after the step event cycle.
REQ-027 SHALL use pointers wrapping modulo DEPTH; CNT range 0..DEPTH; FULL = (CNT==DEPTH); EMPTY = (CNT==0).
REQ-028 SHALL, on write while FULL and no pop that cycle, drop the sample and set OVF; OVF stays set until CLR or reset.
REQ-029 SHALL, on write and pop in the same cycle while FULL, perform both, CNT stays DEPTH, OVF unchanged.
REQ-030 SHALL, on write and RD_RDY while EMPTY, perform the write only; CNT becomes 1.
REQ-031 SHALL pulse MATCH high for exactly one cycle, the cycle after any step event with SEQ==MATCH_VAL while STATE!=IDLE, whether or not the sample is stored.
REQ-032 SHALL give CLR priority over write and pop: CNT=0, pointers=0, OVF=0, STATE=IDLE next cycle, MATCH=0; step_q still samples STEP.

Reset
REQ-033 SHALL, while RST=0, hold STATE=IDLE, CNT=0, EMPTY=1, FULL=0, OVF=0, MATCH=0, RD_VLD=0, RD_SEQ=0, RD_NOM=0, step_q=0.
REQ-034 SHALL discard all FIFO contents on reset asserted mid-operation; no output glitches to non-reset values while RST=0.
REQ-035 SHALL treat STEP=1 in the first cycle after reset release as a step event.

Verification
REQ-036 Reset: RST=0 mid-capture with CNT=5 -> all outputs at REQ-033 values immediately; after release, EMPTY=1.
REQ-037 Free run: EN=1, TRIG=0, generator counts up SEQ 0..7 with 8 step edges, RD_RDY=0 -> CNT=8, FULL=1, OVF=0; draining yields SEQ 0,1,...,7 in order.
REQ-038 Overflow: FIFO full, 9th step edge, RD_RDY=0 -> sample dropped, OVF=1, CNT=8; same edge with RD_RDY=1 -> OVF=0, CNT=8, newest entry at tail.
REQ-039 Trigger: EN=1, TRIG=1, MATCH_VAL=9, generator loaded with 4'h9 after counting 3..8 -> STATE=ARM, nothing stored for 3..8; on 9 -> STATE=RUN, first entry SEQ=9, MATCH pulses one cycle.
REQ-040 Simultaneity: EMPTY with step event and RD_RDY=1 -> CNT=1, RD_VLD=1 next cycle; CLR with step event -> CNT=0, OVF=0, STATE=IDLE.
REQ-041 Enable drop: EN falls in RUN with CNT=3 -> STATE=IDLE, further step edges ignored, stored 3 entries remain readable.
